// File: rtl/lcd_nibble_receiver.sv
// lcd_nibble_receiver: receiving end of a 4-bit HD44780-style LCD bus.
// Samples E/RS/RW/DB with the system clock. Follows the power-on switch from
// 8-bit to 4-bit mode, pairs nibbles into bytes, and flags protocol and timing
// errors.
//
// Optional feature: define LCD_RECV_TIMING_CHECK_EN to build the E-width and
// E-gap checkers. When it is undefined, oTimingError is tied to 0.
//
// Ports:
//   Clock               in  1  system clock, rising edge
//   Reset               in  1  synchronous, active-low reset
//   iLCD_Enabled        in  1  E strobe; the nibble is taken on the falling edge
//   iLCD_RegisterSelect in  1  RS: 0=command, 1=data
//   iLCD_ReadWrite      in  1  RW: strobes with RW=1 are ignored
//   iLCD_Data           in  4  DB[7:4] nibble
//   oByte               out 8  last assembled byte
//   oByteRS             out 1  RS of the last assembled byte
//   oByteValid          out 1  1-cycle pulse when oByte/oByteRS update
//   oMode4Bit           out 1  set once the 4-bit switch command is seen
//   oInitCount          out 2  0x3 commands seen in 8-bit mode, saturates at 3
//   oProtocolError      out 1  sticky: RS changed between the nibbles of a byte
//   oTimingError        out 1  sticky: E width or gap violation
module lcd_nibble_receiver #(
  parameter int unsigned MIN_E_HIGH = 12,
  parameter int unsigned MIN_GAP    = 50,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic [3:0] iLCD_Data,
  output logic [7:0] oByte,
  output logic       oByteRS,
  output logic       oByteValid,
  output logic       oMode4Bit,
  output logic [1:0] oInitCount,
  output logic       oProtocolError,
  output logic       oTimingError
);

  typedef enum logic [1:0] {
    S_MODE8 = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2
  } state_t;

  // Reject configurations whose thresholds cannot be reached by the counters.
  if (CNT_W < 2 || CNT_W > 31 || MIN_E_HIGH >= (1 << CNT_W) || MIN_GAP >= (1 << CNT_W))
  begin : g_param_check
    $error("lcd_nibble_receiver: MIN_E_HIGH/MIN_GAP do not fit in CNT_W");
  end

  // Two sync stages for every input, plus a delay stage on E for edge detection.
  logic       e_q1, e_q2, e_q3;
  logic       rs_q1, rs_q2;
  logic       rw_q1, rw_q2;
  logic [3:0] db_q1, db_q2;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      e_q1  <= 1'b0;
      e_q2  <= 1'b0;
      e_q3  <= 1'b0;
      rs_q1 <= 1'b0;
      rs_q2 <= 1'b0;
      rw_q1 <= 1'b0;
      rw_q2 <= 1'b0;
      db_q1 <= 4'h0;
      db_q2 <= 4'h0;
    end else begin
      e_q1  <= iLCD_Enabled;
      e_q2  <= e_q1;
      e_q3  <= e_q2;
      rs_q1 <= iLCD_RegisterSelect;
      rs_q2 <= rs_q1;
      rw_q1 <= iLCD_ReadWrite;
      rw_q2 <= rw_q1;
      db_q1 <= iLCD_Data;
      db_q2 <= db_q1;
    end
  end

  logic e_fall, e_rise, wr_strobe;
  assign e_fall    = !e_q2 && e_q3;
  assign e_rise    = e_q2 && !e_q3;
  assign wr_strobe = e_fall && !rw_q2;

  state_t     state, state_n;
  logic [3:0] hi_nib, hi_nib_n;
  logic       hi_rs, hi_rs_n;
  logic [7:0] byte_n;
  logic       byte_rs_n, valid_n, mode4_n, perr_n;
  logic [1:0] init_n;

  // State register and registered outputs.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state          <= S_MODE8;
      hi_nib         <= 4'h0;
      hi_rs          <= 1'b0;
      oByte          <= 8'h00;
      oByteRS        <= 1'b0;
      oByteValid     <= 1'b0;
      oMode4Bit      <= 1'b0;
      oInitCount     <= 2'd0;
      oProtocolError <= 1'b0;
    end else begin
      state          <= state_n;
      hi_nib         <= hi_nib_n;
      hi_rs          <= hi_rs_n;
      oByte          <= byte_n;
      oByteRS        <= byte_rs_n;
      oByteValid     <= valid_n;
      oMode4Bit      <= mode4_n;
      oInitCount     <= init_n;
      oProtocolError <= perr_n;
    end
  end

  // Next-state and next-output logic, evaluated once per write strobe.
  always_comb begin
    state_n   = state;
    hi_nib_n  = hi_nib;
    hi_rs_n   = hi_rs;
    byte_n    = oByte;
    byte_rs_n = oByteRS;
    valid_n   = 1'b0;
    mode4_n   = oMode4Bit;
    init_n    = oInitCount;
    perr_n    = oProtocolError;
    if (wr_strobe) begin
      unique case (state)
        S_MODE8: begin
          byte_n    = {db_q2, 4'h0};
          byte_rs_n = rs_q2;
          valid_n   = 1'b1;
          if (!rs_q2 && db_q2 == 4'h3 && oInitCount != 2'd3) begin
            init_n = oInitCount + 2'd1;
          end
          if (!rs_q2 && db_q2 == 4'h2) begin
            mode4_n = 1'b1;
            state_n = S_HIGH;
          end
        end
        S_HIGH: begin
          hi_nib_n = db_q2;
          hi_rs_n  = rs_q2;
          state_n  = S_LOW;
        end
        S_LOW: begin
          if (rs_q2 == hi_rs) begin
            byte_n    = {hi_nib, db_q2};
            byte_rs_n = rs_q2;
            valid_n   = 1'b1;
          end else begin
            perr_n = 1'b1;
          end
          state_n = S_HIGH;
        end
        default: state_n = S_MODE8;
      endcase
    end
  end

`ifdef LCD_RECV_TIMING_CHECK_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] E_HIGH_MIN = CNT_W'(MIN_E_HIGH);
  localparam logic [CNT_W-1:0] GAP_MIN = CNT_W'(MIN_GAP);

  logic [CNT_W-1:0] hi_cnt, gap_cnt;
  logic             first_rise;

  // hi_cnt holds the number of cycles E has been high, and gap_cnt the number
  // of cycles since the last fall. Both counters saturate.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      hi_cnt       <= '0;
      gap_cnt      <= '0;
      first_rise   <= 1'b1;
      oTimingError <= 1'b0;
    end else begin
      if (e_rise) begin
        hi_cnt <= CNT_W'(1);
      end else if (e_q2 && hi_cnt != CNT_MAX) begin
        hi_cnt <= hi_cnt + CNT_W'(1);
      end
      if (e_fall) begin
        gap_cnt <= CNT_W'(1);
      end else if (gap_cnt != CNT_MAX) begin
        gap_cnt <= gap_cnt + CNT_W'(1);
      end
      if (e_rise) begin
        first_rise <= 1'b0;
      end
      if ((e_fall && hi_cnt < E_HIGH_MIN) ||
          (e_rise && !first_rise && gap_cnt < GAP_MIN)) begin
        oTimingError <= 1'b1;
      end
    end
  end
`else
  assign oTimingError = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Self-checking bench for lcd_nibble_receiver. A reference model works on the
// nibble stream and predicts the bytes and flags, which are then compared
// with the bytes the DUT reports.
module tb_lcd_nibble_receiver;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       iLCD_Enabled = 1'b0;
  logic       iLCD_RegisterSelect = 1'b0;
  logic       iLCD_ReadWrite = 1'b0;
  logic [3:0] iLCD_Data = 4'h0;
  logic [7:0] oByte;
  logic       oByteRS, oByteValid, oMode4Bit, oProtocolError, oTimingError;
  logic [1:0] oInitCount;

  lcd_nibble_receiver dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .iLCD_Enabled       (iLCD_Enabled),
    .iLCD_RegisterSelect(iLCD_RegisterSelect),
    .iLCD_ReadWrite     (iLCD_ReadWrite),
    .iLCD_Data          (iLCD_Data),
    .oByte              (oByte),
    .oByteRS            (oByteRS),
    .oByteValid         (oByteValid),
    .oMode4Bit          (oMode4Bit),
    .oInitCount         (oInitCount),
    .oProtocolError     (oProtocolError),
    .oTimingError       (oTimingError)
  );

  always #10 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks the mode, the pending high nibble and the flags.
  bit         m_mode4, m_have_hi, m_hi_rs, m_perr;
  logic [3:0] m_hi;
  int         m_init;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  task automatic model_clear();
    m_mode4 = 0; m_have_hi = 0; m_hi_rs = 0; m_perr = 0; m_hi = 4'h0; m_init = 0;
  endtask

  task automatic model_step(input logic rs, input logic rw, input logic [3:0] nib,
                            output bit ev);
    ev = 0;
    if (rw) return;
    if (!m_mode4) begin
      exp_q.push_back({rs, nib, 4'h0});
      ev = 1;
      if (!rs && nib == 4'h3 && m_init < 3) m_init++;
      if (!rs && nib == 4'h2) begin
        m_mode4 = 1;
        m_have_hi = 0;
      end
    end else if (!m_have_hi) begin
      m_hi = nib; m_hi_rs = rs; m_have_hi = 1;
    end else begin
      m_have_hi = 0;
      if (rs == m_hi_rs) begin
        exp_q.push_back({rs, m_hi, nib});
        ev = 1;
      end else begin
        m_perr = 1;
      end
    end
  endtask

  // Record every byte the DUT reports, sampled on the falling edge.
  always @(negedge Clock) begin
    if (Reset && oByteValid) got_q.push_back({oByteRS, oByte});
  end

  // One E pulse of hi cycles, followed by gap cycles with E low. When lat is
  // set, the byte strobe must appear exactly 3 edges after the fall.
  task automatic strobe(input logic rs, input logic rw, input logic [3:0] nib,
                        input int hi, input int gap, input bit lat);
    bit ev;
    model_step(rs, rw, nib, ev);
    @(posedge Clock); #1;
    iLCD_RegisterSelect = rs; iLCD_ReadWrite = rw; iLCD_Data = nib; iLCD_Enabled = 1'b1;
    repeat (hi) @(posedge Clock);
    #1 iLCD_Enabled = 1'b0;
    if (lat) begin
      repeat (2) @(posedge Clock);
      #1 check("latency_early", 32'(oByteValid), 32'd0);
      @(posedge Clock);
      #1 check("latency_edge3", 32'(oByteValid), 32'(ev));
      repeat (gap - 3) @(posedge Clock);
    end else begin
      repeat (gap) @(posedge Clock);
    end
  endtask

  task automatic rnd_strobe(input logic rs, input logic rw, input logic [3:0] nib);
    strobe(rs, rw, nib, int'($urandom_range(14, 30)), int'($urandom_range(52, 80)), 1'b0);
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_mode4"}, 32'(oMode4Bit), 32'(m_mode4));
    check({tag, "_init"}, 32'(oInitCount), 32'(m_init));
    check({tag, "_perr"}, 32'(oProtocolError), 32'(m_perr));
  endtask

  task automatic do_reset();
    @(posedge Clock); #1;
    Reset = 1'b0; iLCD_Enabled = 1'b0; iLCD_RegisterSelect = 1'b0;
    iLCD_ReadWrite = 1'b0; iLCD_Data = 4'h0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b1;
    model_clear();
    got_q.delete();
    exp_q.delete();
    repeat (2) @(posedge Clock);
  endtask

  initial begin
    model_clear();
    do_reset();
    check("rst_byte", 32'(oByte), 32'd0);
    check("rst_valid", 32'(oByteValid), 32'd0);
    check("rst_mode4", 32'(oMode4Bit), 32'd0);
    check("rst_init", 32'(oInitCount), 32'd0);
    check("rst_perr", 32'(oProtocolError), 32'd0);
    check("rst_terr", 32'(oTimingError), 32'd0);

    // Power-on sequence 3,3,3,2 switches the receiver to 4-bit mode.
    strobe(1'b0, 1'b0, 4'h3, 20, 60, 1'b1);
    strobe(1'b0, 1'b0, 4'h3, 20, 60, 1'b0);
    strobe(1'b0, 1'b0, 4'h3, 20, 60, 1'b0);
    strobe(1'b0, 1'b0, 4'h2, 20, 60, 1'b0);
    check("t1_bytes_direct", 32'(exp_q.size()), 32'd4);
    compare("t1");

    // First 4-bit byte 0x28: no output after the high nibble, one after the low.
    strobe(1'b0, 1'b0, 4'h2, 20, 60, 1'b1);
    strobe(1'b0, 1'b0, 4'h8, 20, 60, 1'b1);
    check("t2_byte", 32'(oByte), 32'h28);
    compare("t2");

    // Data byte with RS=1.
    strobe(1'b1, 1'b0, 4'h4, 20, 60, 1'b0);
    strobe(1'b1, 1'b0, 4'h1, 20, 60, 1'b0);
    check("t3_byte", 32'(oByte), 32'h41);
    check("t3_rs", 32'(oByteRS), 32'd1);
    compare("t3");

    // A read strobe between the two nibbles of a byte is ignored.
    strobe(1'b0, 1'b0, 4'h5, 20, 60, 1'b0);
    strobe(1'b0, 1'b1, 4'hF, 20, 60, 1'b0);
    strobe(1'b0, 1'b0, 4'h7, 20, 60, 1'b0);
    check("t4_byte", 32'(oByte), 32'h57);
    compare("t4");

    // RS mismatch drops the byte; the next pair still assembles.
    strobe(1'b0, 1'b0, 4'h6, 20, 60, 1'b0);
    strobe(1'b1, 1'b0, 4'h9, 20, 60, 1'b0);
    check("t5_perr", 32'(oProtocolError), 32'd1);
    compare("t5a");
    strobe(1'b0, 1'b0, 4'h0, 20, 60, 1'b0);
    strobe(1'b0, 1'b0, 4'h1, 20, 60, 1'b0);
    check("t5_byte", 32'(oByte), 32'h01);
    compare("t5b");
    check("t5_terr", 32'(oTimingError), 32'd0);

    // Reset in the middle of a byte discards the high nibble and returns to 8-bit mode.
    do_reset();
    strobe(1'b0, 1'b0, 4'h2, 20, 60, 1'b0);
    strobe(1'b0, 1'b0, 4'hA, 20, 60, 1'b0);
    compare("t6_pre");
    do_reset();
    strobe(1'b0, 1'b0, 4'hC, 20, 60, 1'b0);
    strobe(1'b0, 1'b0, 4'h3, 20, 60, 1'b0);
    check("t6_mode4", 32'(oMode4Bit), 32'd0);
    compare("t6");

`ifdef LCD_RECV_TIMING_CHECK_EN
    // A short E pulse sets the timing error, and the nibble is still accepted.
    do_reset();
    strobe(1'b0, 1'b0, 4'h5, 5, 60, 1'b0);
    check("t7_terr", 32'(oTimingError), 32'd1);
    compare("t7");
    do_reset();
    check("t7_terr_rst", 32'(oTimingError), 32'd0);
`endif

    // Random traffic: first in 8-bit mode, then after an explicit mode switch.
    do_reset();
    repeat (8) begin
      logic [3:0] nib;
      nib = 4'($urandom_range(0, 15));
      if (nib == 4'h2) nib = 4'h3;
      rnd_strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), nib);
    end
    compare("r8");
    rnd_strobe(1'b0, 1'b0, 4'h2);
    compare("rsw");
    begin
      logic rs;
      rs = 1'b0;
      repeat (60) begin
        if ($urandom_range(0, 9) == 0) rs = ~rs;
        rnd_strobe(rs, 1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
      end
    end
    compare("r4");
    check("r_terr", 32'(oTimingError), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
